// File: rtl/bs_pkg.sv
// Constants and types shared by the sorted-insert writer and the binary-search reader.
// No logic; pure declarations.
// No handshake of its own.
package bs_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [ADDR_W:0]   cnt_t;

   typedef enum logic [2:0] {IDLE, READ, CMP, PLACE, DONE} state_t;
endpackage

// File: rtl/bs_ram.sv
// 32x8 search RAM: synchronous write, registered read (old data on read-during-write).
// Read data valid one cycle after the address.
// No backpressure; accepts an access every cycle.
module bs_ram
   import bs_pkg::*;
(
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wren,
   output logic [DATA_W-1:0] rdata
);

   data_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wren) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/sorted_insert.sv
// Inserts one value per Start into the sorted search RAM, shifting larger entries up.
// Done rises 2e+2 edges after acceptance (e = entries read); Done holds until Start falls.
// Start is a level request; a full table is rejected straight to DONE without writes.
module sorted_insert
   import bs_pkg::*;
(
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   output logic              Done,
   output logic              Full,
   output logic [ADDR_W-1:0] Loc,
   output logic [ADDR_W:0]   Count
);

   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

   state_t state, state_nxt;
   cnt_t   idx, idx_nxt, count, count_nxt;
   data_t  a_reg, a_nxt;
   addr_t  loc, loc_nxt;
   logic   done_q, done_nxt;
   cnt_t   idx_m1;

   assign idx_m1 = idx - cnt_t'(1);

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= IDLE;
         idx    <= '0;
         count  <= '0;
         a_reg  <= '0;
         loc    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         count  <= count_nxt;
         a_reg  <= a_nxt;
         loc    <= loc_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      count_nxt = count;
      a_nxt     = a_reg;
      loc_nxt   = loc;
      done_nxt  = done_q;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wren  = 1'b0;
      case (state)
         IDLE: begin
            done_nxt = 1'b0;
            if (Start) begin
               if (count == DEPTH_C) begin
                  state_nxt = DONE;
               end else begin
                  a_nxt     = A;
                  idx_nxt   = count;
                  state_nxt = (count == '0) ? PLACE : READ;
               end
            end
         end
         READ: begin
            mem_addr  = idx_m1[ADDR_W-1:0];
            state_nxt = CMP;
         end
         CMP: begin
            mem_addr = idx_m1[ADDR_W-1:0];
            // Strictly greater only: equal entries stay below the new value.
            if (mem_rdata > a_reg) begin
               mem_addr  = idx[ADDR_W-1:0];
               mem_wdata = mem_rdata;
               mem_wren  = 1'b1;
               idx_nxt   = idx_m1;
               state_nxt = (idx_m1 == '0) ? PLACE : READ;
            end else begin
               state_nxt = PLACE;
            end
         end
         PLACE: begin
            mem_addr  = idx[ADDR_W-1:0];
            mem_wdata = a_reg;
            mem_wren  = 1'b1;
            loc_nxt   = idx[ADDR_W-1:0];
            count_nxt = count + cnt_t'(1);
            state_nxt = DONE;
         end
         DONE: begin
            // Done is registered, so it rises one edge after entering DONE.
            if (!done_q) begin
               done_nxt = 1'b1;
            end else if (!Start) begin
               done_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign Done  = done_q;
   assign Full  = (count == DEPTH_C);
   assign Loc   = loc;
   assign Count = count;

endmodule

// File: doc/sorted_insert.md
Name: sorted_insert

Overview:
- Writer-side companion to the binary-search reader: inserts one 8-bit value per Start pulse into the 32x8 search RAM, keeping entries 0..Count-1 in ascending order.
- The binary-search block then reads this RAM.
- Shifts larger entries up one address, then writes the new value into the freed slot.
- Same Start/Done handshake style as the search block.

Parameters:
- DATA_W, 8, width of a stored value
- ADDR_W, 5, RAM address width
- DEPTH, 32, entries (= 2**ADDR_W)

Ports:
- clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous active-low reset
- Start  input  1  level request; an insert begins when Start is high in IDLE
- A  input  DATA_W  value to insert, sampled into A_reg on the accepting edge
- mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_addr is presented
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_wren  output  1  RAM write enable
- Done  output  1  insert finished (or rejected); held until Start falls
- Full  output  1  high while Count == DEPTH
- Loc  output  ADDR_W  index where A was written; valid while Done && !Full
- Count  output  ADDR_W+1  number of valid entries

Behaviour:
- Reset (async, Reset_n low):
  - state=IDLE; Count=0; idx=0; A_reg=0; Loc=0.
  - Done, Full and mem_wren are 0 immediately, not on the next edge.
  - mem_addr=0, mem_wdata=0.
  - RAM contents are not cleared; entries at or above Count are don't-care.
- FSM states: IDLE, READ, CMP, PLACE, DONE.
- IDLE:
  - On Start=1 with Count<DEPTH: latch A_reg=A and idx=Count.
  - Go to PLACE if Count==0, else READ.
  - On Start=1 with Count==DEPTH: go to DONE without writing; Loc unchanged.
- READ: mem_addr=idx-1, mem_wren=0.
- CMP (mem_rdata holds entry[idx-1]):
  - If mem_rdata > A_reg (unsigned): write mem_addr=idx, mem_wdata=mem_rdata, mem_wren=1; idx<=idx-1; go to PLACE if idx-1==0, else READ.
  - Otherwise go to PLACE with no write.
  - Equal values are not shifted, so a duplicate lands after the existing equal entries.
- PLACE: write mem_addr=idx, mem_wdata=A_reg, mem_wren=1; Loc<=idx; Count<=Count+1; go to DONE.
- DONE:
  - Done=1; no RAM writes.
  - Return to IDLE when Start==0.
  - Start held high never retriggers: exactly one insert per Start assertion.
- Outputs: mem_wren is high only in CMP-with-shift and in PLACE. Full is combinational on Count==DEPTH.
- Latency, with e = entries read (shifted entries plus 1 if stopped by an entry <= A):
  - Start accepted at edge 0; Done is high after edge 2e+2.
  - Count=0 gives Done after edge 2.
  - Worst case (A smaller than all 31 entries) gives Done after edge 64.
- Arithmetic: all comparisons unsigned DATA_W. idx is ADDR_W+1 bits, so idx=32 never occurs in a write; the maximum write index is 31.
- Inputs change mid-operation: A is ignored after acceptance; Start falling before DONE is ignored and the insert completes.
- Reset mid-insert: the operation aborts, Count returns to 0, and partial RAM contents are abandoned.
- Start and Reset_n are already synchronized upstream; this block adds no synchronizers.

Decomposition:
- Shared package bs_pkg holds:
  - DATA_W, ADDR_W and DEPTH constants, shared with the search block.
  - Typedef state_t enum {IDLE, READ, CMP, PLACE, DONE}.
  - Typedefs data_t and addr_t.
- No RTL sub-module: the FSM and a small datapath (idx counter, A_reg, comparator) sit in one module.
- The bench instantiates the team's existing 32x8 synchronous-read RAM model.

Test Plan:
- Insert into empty: Reset, Start with A=50 -> Loc=0, Count=1, Done high after edge 2, RAM[0]=50.
- Insert in order:
  - Stimulus: insert 10, 30, 20, 5.
  - Final RAM[0..3]: 5, 10, 20, 30; Count=4.
  - Insert of 20 (Count=2): Loc=1, one shift (30 from 1 to 2), Done after edge 6.
  - Insert of 5 (Count=3): Loc=0, three shifts, Done after edge 8.
- Duplicate and boundaries:
  - With 10, 20 stored, insert 20 -> Loc=2, no shift, RAM = 10, 20, 20.
  - Insert 0 and 255 -> 0 at Loc=0, 255 at Loc=Count-1.
- Full and handshake:
  - Insert 32 values -> Full=1.
  - 33rd Start with A=7 -> Done with no mem_wren pulse; Count stays 32; RAM unchanged.
  - Start held high 100 cycles -> exactly one insert; Count +1 only.
- Async reset mid-shift: with Count=10, insert A=0 and drop Reset_n between edges during CMP -> mem_wren and Done low immediately, Count=0, state IDLE; the next insert of 9 gives Loc=0.
